// File: rtl/rc4_pkg.sv
// Shared RC4 key-search definitions: search states, plaintext character
// bounds, default message depth / key width and the character test helper.
package rc4_pkg;

  localparam int unsigned MSG_DEP_DEFAULT  = 32'd32;
  localparam int unsigned KEY_BITS_DEFAULT = 32'd22;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_Z = 8'h7A;

  // Fixed encodings keep the state register compatible with older tooling.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_RD_ADDR   = 3'd3;
  localparam logic [2:0] ST_RD_CHECK  = 3'd4;
  localparam logic [2:0] ST_NEXT_KEY  = 3'd5;
  localparam logic [2:0] ST_FOUND     = 3'd6;
  localparam logic [2:0] ST_FAIL      = 3'd7;

  typedef enum logic [2:0] {
    KS_IDLE      = ST_IDLE,
    KS_LAUNCH    = ST_LAUNCH,
    KS_WAIT_DONE = ST_WAIT_DONE,
    KS_RD_ADDR   = ST_RD_ADDR,
    KS_RD_CHECK  = ST_RD_CHECK,
    KS_NEXT_KEY  = ST_NEXT_KEY,
    KS_FOUND     = ST_FOUND,
    KS_FAIL      = ST_FAIL
  } key_search_state_t;

  function automatic logic is_plain_char(input logic [7:0] c);
    return (c == CHAR_SPACE) || ((c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_Z));
  endfunction

endpackage

// File: rtl/key_search_fsm_if.sv
// Key-search controller bus: start/done handshake with the decrypt pipeline,
// message RAM read port and search status.
interface key_search_fsm_if
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_DEP  = MSG_DEP_DEFAULT,
  parameter int unsigned KEY_BITS = KEY_BITS_DEFAULT
);
  logic                       start;
  logic                       decrypt_done;
  logic [7:0]                 msg_q;
  logic [23:0]                secret_key;
  logic                       decrypt_start;
  logic [$clog2(MSG_DEP)-1:0] msg_address;
  logic [KEY_BITS-1:0]        current_key;
  logic                       busy;
  logic                       key_found;
  logic                       key_failed;

  modport master (
    input  start, decrypt_done, msg_q,
    output secret_key, decrypt_start, msg_address, current_key,
           busy, key_found, key_failed
  );

  modport slave (
    output start, decrypt_done, msg_q,
    input  secret_key, decrypt_start, msg_address, current_key,
           busy, key_found, key_failed
  );
endinterface

// File: rtl/plaintext_char_checker.sv
// Combinational plaintext byte test: space or lowercase ASCII letter.
module plaintext_char_checker
  import rc4_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       valid
);

  assign valid = is_plain_char(char_in);

endmodule

// File: rtl/key_search_fsm.sv
// Brute-force RC4 key search controller. Define KEY_SEARCH_EARLY_EXIT_EN to
// abandon a key on its first bad byte instead of always scanning the full message.
module key_search_fsm
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_DEP   = MSG_DEP_DEFAULT,
  parameter int unsigned KEY_BITS  = KEY_BITS_DEFAULT,
  parameter int unsigned KEY_START = 32'd0,
  parameter int unsigned KEY_END   = (32'd1 << KEY_BITS) - 32'd1
) (
  input logic              CLOCK_50,
  input logic              reset,
  key_search_fsm_if.master bus
);

  localparam int unsigned AW = $clog2(MSG_DEP);
  localparam logic [AW-1:0]       LAST_IDX  = AW'(MSG_DEP - 32'd1);
  localparam logic [AW-1:0]       IDX_ONE   = AW'(32'd1);
  localparam logic [KEY_BITS-1:0] KEY_FIRST = KEY_BITS'(KEY_START);
  localparam logic [KEY_BITS-1:0] KEY_LAST  = KEY_BITS'(KEY_END);
  localparam logic [KEY_BITS-1:0] KEY_ONE   = KEY_BITS'(32'd1);

  key_search_state_t   state_r, state_s;
  logic [KEY_BITS-1:0] key_r, key_s;
  logic [AW-1:0]       idx_r, idx_s;
  logic                char_valid_s;
  logic                decrypt_start_r;
  logic                busy_r;
  logic                found_r;
  logic                failed_r;
`ifndef KEY_SEARCH_EARLY_EXIT_EN
  logic                bad_r, bad_s;
`endif

  plaintext_char_checker u_char_checker (
    .char_in (bus.msg_q),
    .valid   (char_valid_s)
  );

  // Next-state, key and byte-index computation.
  always_comb begin
    state_s = state_r;
    key_s   = key_r;
    idx_s   = idx_r;
`ifndef KEY_SEARCH_EARLY_EXIT_EN
    bad_s   = bad_r;
`endif
    case (state_r)
      KS_IDLE: begin
        if (bus.start) begin
          key_s   = KEY_FIRST;
          state_s = KS_LAUNCH;
        end else begin
          state_s = KS_IDLE;
        end
      end
      KS_LAUNCH: state_s = KS_WAIT_DONE;
      KS_WAIT_DONE: begin
        if (bus.decrypt_done) begin
          idx_s   = '0;
`ifndef KEY_SEARCH_EARLY_EXIT_EN
          bad_s   = 1'b0;
`endif
          state_s = KS_RD_ADDR;
        end else begin
          state_s = KS_WAIT_DONE;
        end
      end
      KS_RD_ADDR: state_s = KS_RD_CHECK;
      KS_RD_CHECK: begin
`ifdef KEY_SEARCH_EARLY_EXIT_EN
        if (!char_valid_s) begin
          state_s = KS_NEXT_KEY;
        end else if (idx_r == LAST_IDX) begin
          state_s = KS_FOUND;
        end else begin
          idx_s   = idx_r + IDX_ONE;
          state_s = KS_RD_ADDR;
        end
`else
        // Sticky bad flag: every key is scanned to the end, so the cost per key is constant.
        if (idx_r == LAST_IDX) begin
          if (bad_r || !char_valid_s) begin
            state_s = KS_NEXT_KEY;
          end else begin
            state_s = KS_FOUND;
          end
        end else begin
          bad_s   = bad_r | ~char_valid_s;
          idx_s   = idx_r + IDX_ONE;
          state_s = KS_RD_ADDR;
        end
`endif
      end
      KS_NEXT_KEY: begin
        if (key_r == KEY_LAST) begin
          state_s = KS_FAIL;
        end else begin
          key_s   = key_r + KEY_ONE;
          state_s = KS_LAUNCH;
        end
      end
      KS_FOUND: state_s = KS_FOUND;
      KS_FAIL:  state_s = KS_FAIL;
      default:  state_s = KS_IDLE;
    endcase
  end

  // State, key, index and output registers; status flags follow the next state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r         <= KS_IDLE;
      key_r           <= KEY_FIRST;
      idx_r           <= '0;
`ifndef KEY_SEARCH_EARLY_EXIT_EN
      bad_r           <= 1'b0;
`endif
      decrypt_start_r <= 1'b0;
      busy_r          <= 1'b0;
      found_r         <= 1'b0;
      failed_r        <= 1'b0;
    end else begin
      state_r         <= state_s;
      key_r           <= key_s;
      idx_r           <= idx_s;
`ifndef KEY_SEARCH_EARLY_EXIT_EN
      bad_r           <= bad_s;
`endif
      decrypt_start_r <= (state_s == KS_LAUNCH);
      busy_r          <= (state_s != KS_IDLE) && (state_s != KS_FOUND) && (state_s != KS_FAIL);
      found_r         <= (state_s == KS_FOUND);
      failed_r        <= (state_s == KS_FAIL);
    end
  end

  assign bus.secret_key    = {{(24 - KEY_BITS){1'b0}}, key_r};
  assign bus.current_key   = key_r;
  assign bus.msg_address   = idx_r;
  assign bus.decrypt_start = decrypt_start_r;
  assign bus.busy          = busy_r;
  assign bus.key_found     = found_r;
  assign bus.key_failed    = failed_r;

endmodule

// File: tb/tb_key_search_fsm.sv
// Directed self-checking bench for key_search_fsm with a behavioural decrypt
// pipeline and 1-cycle-latency message RAM model.
module tb_key_search_fsm;
  import rc4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  key_search_fsm_if #(.MSG_DEP(32), .KEY_BITS(22)) ks ();
  key_search_fsm_if #(.MSG_DEP(32), .KEY_BITS(22)) ks2 ();

  key_search_fsm #(.MSG_DEP(32), .KEY_BITS(22)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (ks.master)
  );

  key_search_fsm #(.MSG_DEP(32), .KEY_BITS(22), .KEY_START(5), .KEY_END(7)) dut2 (
    .CLOCK_50 (clk),
    .reset    (rst2),
    .bus      (ks2.master)
  );

`ifdef KEY_SEARCH_EARLY_EXIT_EN
  localparam int CHK = 12;
`else
  localparam int CHK = 64;
`endif

  int checks = 0;
  int failures = 0;
  int scen = 0;
  logic [7:0] bad_val = 8'h61;
  logic auto_en = 1'b1;
  logic manual_done = 1'b0;
  logic done_ff = 1'b0;
  logic done2_ff = 1'b0;
  int cyc = 0;
  int pulses = 0;
  int pulses2 = 0;
  int pcyc [0:255];

  function automatic logic [7:0] msg_byte(input int s, input logic [21:0] key,
                                          input logic [4:0] addr, input logic [7:0] bv);
    case (s)
      0: return 8'h61;
      1: begin
        if (key == 22'd3) return 8'h7A;
        else if (addr == 5'd5) return 8'h41;
        else return 8'h61;
      end
      2: begin
        if ((addr % 5'd3) == 5'd0) return 8'h20;
        else if ((addr % 5'd3) == 5'd1) return 8'h61;
        else return 8'h7A;
      end
      3: return (addr == 5'd31) ? bv : 8'h61;
      default: return 8'h61;
    endcase
  endfunction

  // Pipeline and RAM models, plus launch bookkeeping.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    done_ff  <= ks.decrypt_start;
    done2_ff <= ks2.decrypt_start;
    ks.msg_q  <= msg_byte(scen, ks.current_key, ks.msg_address, bad_val);
    ks2.msg_q <= 8'h41;
    if (ks.decrypt_start) begin
      pcyc[pulses[7:0]] <= cyc;
      pulses <= pulses + 1;
    end
    if (ks2.decrypt_start) pulses2 <= pulses2 + 1;
  end

  assign ks.decrypt_done  = auto_en ? done_ff : manual_done;
  assign ks2.decrypt_done = done2_ff;

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    ks.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_launch;
    @(negedge clk);
    ks.start = 1'b1;
    @(negedge clk);
    ks.start = 1'b0;
    checks++;
    if (ks.decrypt_start !== 1'b1 || ks.busy !== 1'b1) begin
      failures++;
      $display("FAIL launch: decrypt_start=%b busy=%b, required 1 1", ks.decrypt_start, ks.busy);
    end
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    while (!(ks.key_found || ks.key_failed) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL timeout: no end of search after %0d cycles", n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    ks.start = 1'b1; ks2.start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ks.busy, ks.key_found, ks.key_failed, ks.decrypt_start} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: busy/found/failed/start=%b, required 0000",
               {ks.busy, ks.key_found, ks.key_failed, ks.decrypt_start});
    end
    checks++;
    if (ks.current_key !== 22'd0 || ks.secret_key !== 24'h000000 || ks.msg_address !== 5'd0) begin
      failures++;
      $display("FAIL reset_values: key=%0h secret=%0h addr=%0h, required 0 0 0",
               ks.current_key, ks.secret_key, ks.msg_address);
    end
    checks++;
    if (ks2.current_key !== 22'd5) begin
      failures++;
      $display("FAIL reset_key_start: key=%0d, required 5", ks2.current_key);
    end
    ks.start = 1'b0; ks2.start = 1'b0;
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    checks++;
    if (ks.busy !== 1'b0 || ks.decrypt_start !== 1'b0) begin
      failures++;
      $display("FAIL start_with_reset: busy=%b decrypt_start=%b, required 0 0", ks.busy, ks.decrypt_start);
    end
  endtask

  task automatic test_single_key;
    int p0, n;
    apply_reset();
    scen = 0;
    p0 = pulses;
    do_launch();
    wait_end(500, n);
    checks++;
    if (ks.key_found !== 1'b1 || ks.busy !== 1'b0 || ks.key_failed !== 1'b0) begin
      failures++;
      $display("FAIL single_found: found=%b busy=%b failed=%b, required 1 0 0", ks.key_found, ks.busy, ks.key_failed);
    end
    checks++;
    if (ks.current_key !== 22'd0 || ks.secret_key !== 24'h000000) begin
      failures++;
      $display("FAIL single_key: key=%0h secret=%0h, required 0 0", ks.current_key, ks.secret_key);
    end
    checks++;
    if (pulses - p0 !== 1) begin
      failures++;
      $display("FAIL single_pulses: got %0d, required 1", pulses - p0);
    end
    checks++;
    if (n !== 66) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles, required 66", n);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ks.key_found !== 1'b1 || pulses - p0 !== 1) begin
      failures++;
      $display("FAIL found_hold: found=%b pulses=%0d, required 1 1", ks.key_found, pulses - p0);
    end
  endtask

  task automatic test_multi_key;
    int p0, n, gap;
    apply_reset();
    scen = 1;
    p0 = pulses;
    do_launch();
    wait_end(2000, n);
    checks++;
    if (ks.key_found !== 1'b1 || ks.current_key !== 22'd3 || ks.secret_key !== 24'h000003) begin
      failures++;
      $display("FAIL multi_found: found=%b key=%0d secret=%0h, required 1 3 3",
               ks.key_found, ks.current_key, ks.secret_key);
    end
    checks++;
    if (pulses - p0 !== 4) begin
      failures++;
      $display("FAIL multi_pulses: got %0d, required 4", pulses - p0);
    end
    gap = pcyc[p0 + 1] - pcyc[p0];
    checks++;
    if (gap !== CHK + 3) begin
      failures++;
      $display("FAIL multi_key_gap: got %0d cycles, required %0d", gap, CHK + 3);
    end
    checks++;
    if (n !== 3 * (CHK + 3) + 66) begin
      failures++;
      $display("FAIL multi_latency: got %0d, required %0d", n, 3 * (CHK + 3) + 66);
    end
  endtask

  task automatic test_key_range;
    int n;
    @(negedge clk);
    ks2.start = 1'b1;
    @(negedge clk);
    ks2.start = 1'b0;
    n = 0;
    while (!ks2.key_failed && !ks2.key_found && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ks2.key_failed !== 1'b1 || ks2.key_found !== 1'b0 || ks2.busy !== 1'b0) begin
      failures++;
      $display("FAIL range_failed: failed=%b found=%b busy=%b, required 1 0 0", ks2.key_failed, ks2.key_found, ks2.busy);
    end
    checks++;
    if (ks2.current_key !== 22'd7 || pulses2 !== 3) begin
      failures++;
      $display("FAIL range_key: key=%0d launches=%0d, required 7 3", ks2.current_key, pulses2);
    end
    ks2.start = 1'b1;
    repeat (4) @(negedge clk);
    ks2.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ks2.current_key !== 22'd7 || pulses2 !== 3 || ks2.key_failed !== 1'b1) begin
      failures++;
      $display("FAIL range_hold: key=%0d launches=%0d failed=%b, required 7 3 1", ks2.current_key, pulses2, ks2.key_failed);
    end
  endtask

  task automatic test_char_bounds;
    logic [7:0] rej [3] = '{8'h1F, 8'h60, 8'h7B};
    int n, p0;
    apply_reset();
    scen = 2;
    do_launch();
    wait_end(500, n);
    checks++;
    if (ks.key_found !== 1'b1 || ks.current_key !== 22'd0) begin
      failures++;
      $display("FAIL accept_bounds: found=%b key=%0d, required 1 0", ks.key_found, ks.current_key);
    end
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      scen = 3;
      bad_val = rej[i];
      p0 = pulses;
      do_launch();
      n = 0;
      while (pulses < p0 + 2 && !ks.key_found && n < 300) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (ks.key_found !== 1'b0 || ks.current_key !== 22'd1) begin
        failures++;
        $display("FAIL reject_%0h: found=%b key=%0d, required 0 1", rej[i], ks.key_found, ks.current_key);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    apply_reset();
    scen = 1;
    auto_en = 1'b1;
    do_launch();
    n = 0;
    while (!(ks.decrypt_start && ks.current_key == 22'd2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    auto_en = 1'b0;
    checks++;
    if (ks.current_key !== 22'd2) begin
      failures++;
      $display("FAIL mid_reach_key2: key=%0d, required 2", ks.current_key);
    end
    @(negedge clk);
    checks++;
    if (ks.busy !== 1'b1 || ks.decrypt_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_done: busy=%b decrypt_start=%b, required 1 0", ks.busy, ks.decrypt_start);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ks.busy !== 1'b0 || ks.current_key !== 22'd0) begin
      failures++;
      $display("FAIL mid_reset_idle: busy=%b key=%0d, required 0 0", ks.busy, ks.current_key);
    end
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ks.busy !== 1'b0 || ks.decrypt_start !== 1'b0 || ks.msg_address !== 5'd0) begin
      failures++;
      $display("FAIL stray_done: busy=%b decrypt_start=%b addr=%0d, required 0 0 0",
               ks.busy, ks.decrypt_start, ks.msg_address);
    end
    auto_en = 1'b1;
    scen = 0;
    do_launch();
    checks++;
    if (ks.current_key !== 22'd0 || ks.secret_key !== 24'h000000) begin
      failures++;
      $display("FAIL restart_key: key=%0d secret=%0h, required 0 0", ks.current_key, ks.secret_key);
    end
    wait_end(500, n);
    checks++;
    if (ks.key_found !== 1'b1 || ks.current_key !== 22'd0) begin
      failures++;
      $display("FAIL restart_found: found=%b key=%0d, required 1 0", ks.key_found, ks.current_key);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    ks.start = 1'b0;
    ks2.start = 1'b0;
    test_reset();
    test_single_key();
    test_multi_key();
    test_key_range();
    test_char_bounds();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_search_fsm.md
# key_search_fsm

Brute-force RC4 key search controller, directly downstream of the per-key decrypt pipeline (S init, shuffle, S readout, decryptor). Each iteration presents a candidate key, launches the pipeline, waits for `decrypt_done`, then reads the decrypted message through a 1-cycle-latency RAM port and checks every byte is lowercase ASCII or space. It stops on the first valid key, or when the key range is exhausted.

## Interface
Parameters:
- `MSG_DEP`, 32: message length in bytes.
- `KEY_BITS`, 22: searched key width.
- `KEY_START`, 0: first candidate key.
- `KEY_END`, 2^22-1: last candidate key (inclusive, ≥ `KEY_START`).

Ports:
- `CLOCK_50`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a search; sampled only in IDLE.
- `decrypt_done`  in  1  pipeline finished for the current key; sampled only in WAIT_DONE.
- `msg_q`  in  8  decrypted-message RAM read data.
- `secret_key`  out  24  `{(24-KEY_BITS)'b0, current_key}`, fed to the shuffle stage.
- `decrypt_start`  out  1  one-cycle pulse that launches the pipeline.
- `msg_address`  out  $clog2(MSG_DEP)  message RAM read address.
- `current_key`  out  KEY_BITS  candidate under test.
- `busy`  out  1  high in every state except IDLE, FOUND and FAIL.
- `key_found`  out  1  level; high in FOUND.
- `key_failed`  out  1  level; high in FAIL.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, RD_ADDR, RD_CHECK, NEXT_KEY, FOUND, FAIL.
- IDLE: `start` loads `current_key <= KEY_START` and moves to LAUNCH.
- LAUNCH: `decrypt_start = 1` for exactly this cycle, then WAIT_DONE.
- WAIT_DONE: hold until `decrypt_done = 1`, then clear the byte index and go to RD_ADDR.
- RD_ADDR: drive `msg_address = idx`, then RD_CHECK.
- RD_CHECK: compare `msg_q` (the byte at `idx`).
  - Valid byte: 0x20, or 0x61..0x7A inclusive.
  - Valid and `idx == MSG_DEP-1` → FOUND.
  - Valid otherwise → `idx + 1`, RD_ADDR.
  - Invalid byte → see Configuration.
- NEXT_KEY:
  - `current_key == KEY_END` → FAIL.
  - Otherwise `current_key + 1` → LAUNCH.
  - No wrap-around: the key is never incremented past `KEY_END`.
- FOUND and FAIL hold, with `current_key` frozen, until `reset`. `start` is ignored there.
- `start` while busy is ignored. `decrypt_done` outside WAIT_DONE is ignored.
- `reset` wins over every simultaneous input, including `start` and `decrypt_done`.
- `reset` mid-search (any state) returns to IDLE on the next edge and aborts the search. It does not reset the downstream pipeline; the top level does that.

## Timing
- Reset values: state IDLE, `current_key = KEY_START`, `msg_address = 0`, `decrypt_start = 0`, `busy = 0`, `key_found = 0`, `key_failed = 0`.
- `start` high at edge n: LAUNCH in cycle n+1, with `secret_key` already the new key and `decrypt_start` high.
- RAM contract: `msg_q` during RD_CHECK reflects the `msg_address` registered on entry to RD_ADDR (1-cycle read latency).
- Check cost is 2 cycles per byte; a full passing scan takes 2·MSG_DEP cycles.
- After the last byte check: `key_found` is high one cycle later, and `busy` falls in the same cycle.
- Per-key overhead outside the check: LAUNCH (1) + WAIT_DONE (≥1) + NEXT_KEY (1).
- All outputs are registered or decoded from the state register only; there is no input-to-output combinational path.

## Configuration
- `KEY_SEARCH_EARLY_EXIT_EN` defined: the first invalid byte goes directly to NEXT_KEY.
- Undefined: an invalid byte sets a sticky `bad` flag and the scan continues. After the last byte, `bad` selects NEXT_KEY or FOUND. Every key then costs exactly 2·MSG_DEP check cycles.

## Structure
- Shared package `rc4_pkg`: state enum `key_search_state_t`, `CHAR_SPACE = 8'h20`, `CHAR_LOWER_A = 8'h61`, `CHAR_LOWER_Z = 8'h7A`, `MSG_DEP` default, key width default.
- One sub-module, `plaintext_char_checker`: combinational 8-bit in, 1-bit `valid` out. It is reused by later parallel-core search blocks.

## Test plan
- Reset: assert `reset` 2 cycles → all outputs at reset values. `start` together with `reset` → remains IDLE.
- Pipeline model returns 32×0x61 for key 0:
  - `start` → `key_found = 1`, `current_key = 0`, `secret_key = 24'h000000`.
  - Exactly one `decrypt_start` pulse.
- Model returns byte 5 = 0x41 for keys 0..2 and all 0x7A for key 3:
  - Found with `current_key = 3` and four `decrypt_start` pulses.
  - EARLY_EXIT_EN: 12 check cycles per failed key; without it, 64.
- `KEY_START = 5`, `KEY_END = 7`, messages never valid:
  - `key_failed = 1`, `current_key = 7`, three launches, no wrap to 8.
- Character boundaries:
  - 0x20, 0x61 and 0x7A accepted.
  - 0x1F, 0x60 and 0x7B each rejected when placed at byte 31 only.
- `reset` pulsed during WAIT_DONE:
  - IDLE next cycle.
  - A following `decrypt_done` pulse causes no transition.
  - A new `start` restarts from `KEY_START`.
